// File: rtl/wt_write_buffer_if.sv
// Bundle of store, read-miss check and memory write-port signals for the
// write-through buffer.
interface wt_write_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_full;
    logic              buf_empty;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] chk_addr;
    logic              chk_hit;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic              ovf_err;

    modport slave (
        input  wr_req, wr_addr, wr_data, chk_addr, mem_ack,
        output wr_full, buf_empty, count, chk_hit, mem_we, mem_addr, mem_wdata, ovf_err
    );

    modport master (
        output wr_req, wr_addr, wr_data, chk_addr, mem_ack,
        input  wr_full, buf_empty, count, chk_hit, mem_we, mem_addr, mem_wdata, ovf_err
    );
endinterface

// File: rtl/wt_write_buffer.sv
// Posted-write FIFO between the write-through data cache and data memory:
// absorbs stores, drains them one at a time over mem_we/mem_ack.
module wt_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               rstn,
    wt_write_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              ovf_q;
    logic              full, push, load, pop, hit;
    logic [DEPTH-1:0]  push_mask, pop_mask;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign push      = bus.wr_req && !full;
    assign push_mask = push ? (DEPTH'(1) << wr_ptr_q) : '0;
    assign pop_mask  = pop  ? (DEPTH'(1) << rd_ptr_q) : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (count_q != '0) begin
                state_d = SEND;
                load    = 1'b1;
            end
            SEND: if (bus.mem_ack) begin
                state_d = IDLE;
                pop     = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            if (push) begin
                addr_q[wr_ptr_q] <= bus.wr_addr;
                data_q[wr_ptr_q] <= bus.wr_data;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (load) begin
                mem_addr_q  <= addr_q[rd_ptr_q];
                mem_wdata_q <= data_q[rd_ptr_q];
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            // Push never targets the popped slot: a full buffer refuses the push.
            valid_q <= (valid_q & ~pop_mask) | push_mask;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (bus.wr_req && full) ovf_q <= 1'b1;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == bus.chk_addr)) hit = 1'b1;
        end
    end

    assign bus.wr_full   = full;
    assign bus.buf_empty = (count_q == '0) && (state_q == IDLE);
    assign bus.count     = count_q;
    assign bus.chk_hit   = hit;
    assign bus.mem_we    = (state_q == SEND);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.ovf_err   = ovf_q;
endmodule

// File: tb/tb_wt_write_buffer.sv
// Testbench for wt_write_buffer: directed table, corner sequences and random
// traffic checked against a queue-based model of the buffer.
module tb_wt_write_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic clk;
    logic rstn;

    wt_write_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wt_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    // Model: pending stores in issue order; head is the one being sent when m_send.
    ent_t mq[$];
    bit   m_send;
    bit   m_ovf;
    bit   dut_wrote;
    ent_t dut_wr;

    typedef struct {
        bit                req;
        logic [ADDR_W-1:0] a;
        bit                ack;
        logic [2:0]        cnt;
        bit                full;
        bit                we;
        logic [ADDR_W-1:0] maddr;
        bit                ovf;
        bit                hit;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit req, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input bit ack, input logic [ADDR_W-1:0] c);
        bus.wr_req   = req;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.mem_ack  = ack;
        bus.chk_addr = c;
    endtask

    task automatic check_model(input string tag);
        bit hit;
        hit = 1'b0;
        foreach (mq[i]) if (mq[i].a == bus.chk_addr) hit = 1'b1;
        chk({tag, ".count"}, 64'(bus.count), 64'(mq.size()));
        chk({tag, ".wr_full"}, 64'(bus.wr_full), 64'(mq.size() == DEPTH));
        chk({tag, ".buf_empty"}, 64'(bus.buf_empty), 64'(mq.size() == 0 && !m_send));
        chk({tag, ".mem_we"}, 64'(bus.mem_we), 64'(m_send));
        chk({tag, ".chk_hit"}, 64'(bus.chk_hit), 64'(hit));
        chk({tag, ".ovf_err"}, 64'(bus.ovf_err), 64'(m_ovf));
        if (m_send && mq.size() != 0) begin
            chk({tag, ".mem_addr"}, 64'(bus.mem_addr), 64'(mq[0].a));
            chk({tag, ".mem_wdata"}, 64'(bus.mem_wdata), 64'(mq[0].d));
        end
    endtask

    task automatic step(input string tag);
        bit   pre_full, do_push, do_load, do_pop, ovf_now;
        ent_t e;
        pre_full  = (mq.size() == DEPTH);
        do_push   = bus.wr_req && !pre_full;
        do_load   = !m_send && mq.size() != 0;
        do_pop    = m_send && bus.mem_ack;
        ovf_now   = bus.wr_req && pre_full;
        e.a       = bus.wr_addr;
        e.d       = bus.wr_data;
        dut_wrote = bus.mem_we && bus.mem_ack;
        dut_wr.a  = bus.mem_addr;
        dut_wr.d  = bus.mem_wdata;
        @(posedge clk);
        #1;
        cyc++;
        if (do_pop) begin
            mq.delete(0);
            m_send = 1'b0;
        end else if (do_load) begin
            m_send = 1'b1;
        end
        if (do_push) mq.push_back(e);
        if (ovf_now) m_ovf = 1'b1;
        check_model(tag);
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0, '0);
        rstn = 1'b0;
        mq.delete();
        m_send = 1'b0;
        m_ovf  = 1'b0;
        #2;
        check_model("rst");
        chk("rst.mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst.mem_wdata", 64'(bus.mem_wdata), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check_model("rst_rel");
    endtask

    initial begin
        int   hi, nwr, last, niss;
        ent_t exp_wr[10];
        ent_t ne;

        rstn = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0);

        // Fill/overflow/drain table: chk_addr held at 2, data = 0x100 + addr.
        tv[0]  = '{1'b1, 10'd1, 1'b0, 3'd1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 10'd2, 1'b0, 3'd2, 1'b0, 1'b1, 10'd1, 1'b0, 1'b1};
        tv[2]  = '{1'b1, 10'd3, 1'b0, 3'd3, 1'b0, 1'b1, 10'd1, 1'b0, 1'b1};
        tv[3]  = '{1'b1, 10'd4, 1'b0, 3'd4, 1'b1, 1'b1, 10'd1, 1'b0, 1'b1};
        tv[4]  = '{1'b1, 10'd5, 1'b0, 3'd4, 1'b1, 1'b1, 10'd1, 1'b1, 1'b1};
        tv[5]  = '{1'b0, 10'd0, 1'b1, 3'd3, 1'b0, 1'b0, 10'd0, 1'b1, 1'b1};
        tv[6]  = '{1'b0, 10'd0, 1'b0, 3'd3, 1'b0, 1'b1, 10'd2, 1'b1, 1'b1};
        tv[7]  = '{1'b0, 10'd0, 1'b1, 3'd2, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 10'd0, 1'b0, 3'd2, 1'b0, 1'b1, 10'd3, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 10'd0, 1'b1, 3'd1, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0};
        tv[10] = '{1'b0, 10'd0, 1'b0, 3'd1, 1'b0, 1'b1, 10'd4, 1'b1, 1'b0};
        tv[11] = '{1'b0, 10'd0, 1'b1, 3'd0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(tv[i].req, tv[i].a, 32'h100 + 32'(tv[i].a), tv[i].ack, 10'd2);
            step("fill");
            chk("tbl.count", 64'(bus.count), 64'(tv[i].cnt));
            chk("tbl.wr_full", 64'(bus.wr_full), 64'(tv[i].full));
            chk("tbl.mem_we", 64'(bus.mem_we), 64'(tv[i].we));
            chk("tbl.ovf_err", 64'(bus.ovf_err), 64'(tv[i].ovf));
            chk("tbl.chk_hit", 64'(bus.chk_hit), 64'(tv[i].hit));
            if (tv[i].we) begin
                chk("tbl.mem_addr", 64'(bus.mem_addr), 64'(tv[i].maddr));
                chk("tbl.mem_wdata", 64'(bus.mem_wdata), 64'(32'h100 + 32'(tv[i].maddr)));
            end
        end
        chk("tbl.buf_empty", 64'(bus.buf_empty), 64'd1);

        // Asynchronous reset in the middle of a memory write with three entries held.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 10'(32'h20 + k), 32'hA000 + 32'(k), 1'b0, '0);
            step("pre_rst");
        end
        drive(1'b0, '0, '0, 1'b0, '0);
        chk("mid.count", 64'(bus.count), 64'd3);
        chk("mid.mem_we", 64'(bus.mem_we), 64'd1);
        #3;
        rstn = 1'b0;
        #1;
        chk("async.mem_we", 64'(bus.mem_we), 64'd0);
        chk("async.count", 64'(bus.count), 64'd0);
        mq.delete();
        m_send = 1'b0;
        m_ovf  = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("async.buf_empty", 64'(bus.buf_empty), 64'd1);
        chk("async.count_rel", 64'(bus.count), 64'd0);

        // Single store, acknowledged on the third request cycle.
        do_reset();
        drive(1'b1, 10'h010, 32'hDEADBEEF, 1'b0, '0);
        step("single");
        drive(1'b0, '0, '0, 1'b0, '0);
        chk("single.lat_we", 64'(bus.mem_we), 64'd0);
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.mem_we) begin
                hi++;
                chk("single.addr", 64'(bus.mem_addr), 64'h010);
                chk("single.data", 64'(bus.mem_wdata), 64'hDEADBEEF);
            end
            bus.mem_ack = (hi == 3);
            step("single");
            if (!bus.mem_we && hi > 0) break;
        end
        bus.mem_ack = 1'b0;
        chk("single.we_cycles", 64'(hi), 64'd3);
        chk("single.count", 64'(bus.count), 64'd0);
        chk("single.empty", 64'(bus.buf_empty), 64'd1);

        // Push and pop on the same edge.
        do_reset();
        drive(1'b1, 10'h0A1, 32'h1111, 1'b0, '0);
        step("pp");
        drive(1'b1, 10'h0A2, 32'h2222, 1'b0, '0);
        step("pp");
        chk("pp.count_pre", 64'(bus.count), 64'd2);
        drive(1'b1, 10'h0A3, 32'h3333, 1'b1, '0);
        step("pp");
        chk("pp.count_same", 64'(bus.count), 64'd2);
        drive(1'b0, '0, '0, 1'b0, '0);
        step("pp");
        chk("pp.next_addr", 64'(bus.mem_addr), 64'h0A2);
        chk("pp.next_data", 64'(bus.mem_wdata), 64'h2222);

        // Ten stores with ack tied high: order, spacing and pointer wrap.
        do_reset();
        nwr  = 0;
        niss = 0;
        last = -1;
        for (int k = 0; k < 80 && nwr < 10; k++) begin
            if (niss < 10 && mq.size() < DEPTH) begin
                ne.a = 10'(niss * 37 + 5);
                ne.d = $urandom;
                exp_wr[niss] = ne;
                niss++;
                drive(1'b1, ne.a, ne.d, 1'b1, '0);
            end else begin
                drive(1'b0, '0, '0, 1'b1, '0);
            end
            step("wrap");
            if (dut_wrote) begin
                chk("wrap.addr", 64'(dut_wr.a), 64'(exp_wr[nwr].a));
                chk("wrap.data", 64'(dut_wr.d), 64'(exp_wr[nwr].d));
                if (last >= 0) chk("wrap.spacing", 64'(cyc - last), 64'd2);
                last = cyc;
                nwr++;
            end
        end
        chk("wrap.writes", 64'(nwr), 64'd10);

        // chk_hit against a pending store to the top word.
        do_reset();
        drive(1'b1, 10'h3FF, 32'hCAFE0001, 1'b0, 10'h3FF);
        step("hit");
        drive(1'b0, '0, '0, 1'b0, 10'h3FF);
        #1;
        chk("hit.pending", 64'(bus.chk_hit), 64'd1);
        bus.chk_addr = 10'h3FE;
        #1;
        chk("hit.other", 64'(bus.chk_hit), 64'd0);
        bus.chk_addr = 10'h3FF;
        step("hit");
        chk("hit.sending", 64'(bus.chk_hit), 64'd1);
        bus.mem_ack = 1'b1;
        step("hit");
        bus.mem_ack = 1'b0;
        #1;
        chk("hit.popped", 64'(bus.chk_hit), 64'd0);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            drive($urandom_range(0, 99) < 60, 10'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)));
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
